vga_timing_monitor: RTL
=======================

# vga_timing_monitor

Receive-side checker for the 1024x768 @ 65 MHz VGA timing stream (hsync, vsync, hblnk, vblnk, all active-high). It recovers the pixel coordinates from the blanking edges and measures line and frame lengths. It also checks sync pulse placement against the expected timing and runs a lock state machine. It sits downstream of the timing generator, or on a loop-back of its outputs, and qualifies the stream before pixel logic uses it.

## Interface
- H_TOTAL, 1344, expected clocks per line
- H_SYNC_START, 1048, expected recovered hcount of hsync rise
- H_SYNC_WIDTH, 136, expected hsync high length in clocks
- V_TOTAL, 806, expected lines per frame
- V_SYNC_START, 771, expected recovered vcount of vsync rise
- V_SYNC_WIDTH, 6, expected vsync high length in lines
- LOCK_FRAMES, 2, consecutive clean frames required to lock (1..15)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing stream
- hcount_out  out  11  recovered horizontal position
- vcount_out  out  10  recovered vertical position
- frame_start  out  1  one-cycle pulse when the recovered coordinate is (0,0)
- h_total_meas  out  11  last measured line length
- v_total_meas  out  10  last measured frame length in lines
- locked  out  1  high in state LOCKED
- err_pulse  out  1  one-cycle pulse on any error detected in CHECK or LOCKED
- err_code  out  3  valid with err_pulse; bit0 horizontal, bit1 vertical, bit2 sync placement

## Operation
- Stage 1 registers all four inputs (s_*). Stage 2 holds delayed copies (s_*_d) and the counters. Edge terms compare s_* with s_*_d.
- Line start (hfall) is s_hblnk=0 and s_hblnk_d=1. Frame start (vfall) is hfall together with s_vblnk=0 and s_vblnk_d=1.
- On hfall, h_ctr is set to 0. Otherwise it increments, saturating at 2047.
- On vfall, v_ctr is set to 0. On hfall without vfall, v_ctr increments, saturating at 1023.
- hcount_out = h_ctr and vcount_out = v_ctr.
- On hfall, h_total_meas is loaded with h_ctr+1 (the previous line length, computed 11-bit before the clear).
- On vfall, v_total_meas is loaded with v_ctr+1.
- Errors are computed at stage 2 on the next counter values (h_n, v_n):
  - bit0: hfall with h_ctr+1 != H_TOTAL, or h_ctr reaches 2047.
  - bit1: vfall with v_ctr+1 != V_TOTAL, or v_ctr reaches 1023.
  - bit2, hsync: hsync rise with h_n != H_SYNC_START, or hsync fall with h_n != H_SYNC_START+H_SYNC_WIDTH.
  - bit2, vsync: vsync rise unless h_n=0 and v_n=V_SYNC_START, or vsync fall unless h_n=0 and v_n=V_SYNC_START+V_SYNC_WIDTH.
  - Multiple bits may be set in the same cycle.
- FSM states:
  - SEARCH (reset state): errors are ignored. vfall goes to CHECK and clears good_cnt and frame_bad.
  - CHECK: any error goes to SEARCH. On vfall, good_cnt increments; when good_cnt+1 = LOCK_FRAMES the FSM goes to LOCKED.
  - LOCKED: any error goes to SEARCH. Otherwise the FSM stays in LOCKED.
- When an error and vfall occur in the same cycle, the error wins: the FSM goes to SEARCH and that vfall is not used as a frame start.
- Missing sync pulses are not detected. Only misplaced edges are flagged.

## Timing
- Latency from input to hcount_out/vcount_out is 2 clk. Once locked, both outputs equal the generator's counts delayed by 2 clk.
- frame_start, locked, err_pulse, err_code and the FSM state all update on the same edge as the counters, so they align with hcount_out/vcount_out.
- locked rises in the cycle where hcount_out=0 and vcount_out=0 at the LOCK_FRAMES-th clean frame boundary after entering CHECK.
- locked falls in the cycle where err_pulse is high.
- Asynchronous reset clears every register to 0:
  - All outputs read 0, with locked=0 and err_pulse=0.
  - The state returns to SEARCH.
  - Reset during LOCKED drops locked immediately, without waiting for a clock edge.
- err_code holds its last value when err_pulse is low; it is 0 after reset.

## Test plan
- Nominal lock:
  - Stimulus: generator and monitor released from reset together, default parameters.
  - Required: frame_start every 1083264 clk; h_total_meas=1344, v_total_meas=806; locked rises at the 3rd frame_start (cycle 3*1083264+2); err_pulse never asserts.
- Coordinate tracking:
  - Stimulus: locked stream.
  - Required: hcount_out/vcount_out equal the generator counts 2 clk earlier for a full frame; the hsync rise is seen at hcount_out=1048; the vsync rise at (0,771).
- Short line:
  - Stimulus: one line shortened to 1340 clk while locked.
  - Required: at that hfall, err_pulse=1 with err_code=3'b001 and h_total_meas=1340; locked drops in the same cycle; the FSM returns to SEARCH and relocks after 3 further frame boundaries.
- Misplaced hsync:
  - Stimulus: hsync rise at hcount 1050 while in CHECK.
  - Required: err_code=3'b100; the FSM goes to SEARCH; locked stays 0.
- Signal loss:
  - Stimulus: hblnk held low while locked.
  - Required: hcount_out saturates at 2047 and err_code bit0 sets; locked drops; vcount_out stops advancing.
- Reset mid-frame:
  - Stimulus: rst asserted asynchronously while locked at (500,300).
  - Required: all outputs read 0 immediately; after release, the FSM stays in SEARCH until the next vfall.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers pixel coordinates from a VGA timing stream, measures line/frame
// lengths, checks sync edge placement and qualifies the stream with a SEARCH/CHECK/LOCKED FSM.
module vga_timing_monitor #(
    parameter int H_TOTAL      = 1344,
    parameter int H_SYNC_START = 1048,
    parameter int H_SYNC_WIDTH = 136,
    parameter int V_TOTAL      = 806,
    parameter int V_SYNC_START = 771,
    parameter int V_SYNC_WIDTH = 6,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        frame_start,
    output logic [10:0] h_total_meas,
    output logic [9:0]  v_total_meas,
    output logic        locked,
    output logic        err_pulse,
    output logic [2:0]  err_code
);
    localparam logic [10:0] HT  = 11'(H_TOTAL);
    localparam logic [10:0] HSR = 11'(H_SYNC_START);
    localparam logic [10:0] HSF = 11'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [9:0]  VT  = 10'(V_TOTAL);
    localparam logic [9:0]  VSR = 10'(V_SYNC_START);
    localparam logic [9:0]  VSF = 10'(V_SYNC_START + V_SYNC_WIDTH);
    localparam logic [3:0]  LF  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    // Bit order of both stream stages: {hsync, vsync, hblnk, vblnk}
    logic [3:0]  s1_q, s2_q;
    logic [10:0] h_ctr_q, h_n, h_inc, h_meas_q;
    logic [9:0]  v_ctr_q, v_n, v_inc, v_meas_q;
    logic [3:0]  good_q, good_d;
    logic [2:0]  err_d, err_code_q;
    logic        hfall, vfall, hs_rise, hs_fall, vs_rise, vs_fall, err_valid;
    logic        frame_start_q, err_pulse_q;
    state_t      state_q, state_d;

    always_comb begin
        hfall   = !s1_q[1] && s2_q[1];
        vfall   = hfall && !s1_q[0] && s2_q[0];
        hs_rise = s1_q[3] && !s2_q[3];
        hs_fall = !s1_q[3] && s2_q[3];
        vs_rise = s1_q[2] && !s2_q[2];
        vs_fall = !s1_q[2] && s2_q[2];
        h_inc   = h_ctr_q + 11'd1;
        v_inc   = v_ctr_q + 10'd1;
        h_n     = hfall ? '0 : (&h_ctr_q) ? h_ctr_q : h_inc;
        v_n     = vfall ? '0 : (hfall && !(&v_ctr_q)) ? v_inc : v_ctr_q;
        err_d[0] = (hfall && h_inc != HT) || (&h_n);
        err_d[1] = (vfall && v_inc != VT) || (&v_n);
        err_d[2] = (hs_rise && h_n != HSR) || (hs_fall && h_n != HSF)
                || (vs_rise && (h_n != '0 || v_n != VSR))
                || (vs_fall && (h_n != '0 || v_n != VSF));
        err_valid = state_q != SEARCH && |err_d;
    end

    // An error outranks a simultaneous frame start outside SEARCH
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (state_q == SEARCH) begin
            state_d = vfall ? CHECK : SEARCH;
            good_d  = vfall ? '0 : good_q;
        end else if (|err_d) begin
            state_d = SEARCH;
        end else if (vfall && state_q == CHECK) begin
            good_d  = good_q + 4'd1;
            state_d = (good_q + 4'd1 == LF) ? LOCKED : CHECK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            h_ctr_q       <= '0;
            v_ctr_q       <= '0;
            h_meas_q      <= '0;
            v_meas_q      <= '0;
            good_q        <= '0;
            err_code_q    <= '0;
            frame_start_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            state_q       <= SEARCH;
        end else begin
            s1_q          <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
            s2_q          <= s1_q;
            h_ctr_q       <= h_n;
            v_ctr_q       <= v_n;
            h_meas_q      <= hfall ? h_inc : h_meas_q;
            v_meas_q      <= vfall ? v_inc : v_meas_q;
            good_q        <= good_d;
            err_code_q    <= err_valid ? err_d : err_code_q;
            frame_start_q <= vfall;
            err_pulse_q   <= err_valid;
            state_q       <= state_d;
        end
    end

    assign hcount_out   = h_ctr_q;
    assign vcount_out   = v_ctr_q;
    assign frame_start  = frame_start_q;
    assign h_total_meas = h_meas_q;
    assign v_total_meas = v_meas_q;
    assign locked       = state_q == LOCKED;
    assign err_pulse    = err_pulse_q;
    assign err_code     = err_code_q;
endmodule
